wb_timer: RTL

//  Wishbone B4 classic slave timer/compare unit on the SoC intercon, next to ram0 and uart0.

---
 rtl/wb_timer_pkg.sv | 50 +++++
 rtl/wb_timer_prescaler.sv | 46 ++++
 rtl/wb_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_pkg
// Description : Shared definitions for the wb_timer Wishbone timer/compare
//               unit: register word indices, CTRL/STATUS bit positions,
//               COMPARE reset value and a byte-lane merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_timer_pkg;

    // Register word indices (bus adr[4:2])
    localparam logic [2:0] C_REG_CTRL     = 3'd0;
    localparam logic [2:0] C_REG_PRESCALE = 3'd1;
    localparam logic [2:0] C_REG_COUNT    = 3'd2;
    localparam logic [2:0] C_REG_COMPARE  = 3'd3;
    localparam logic [2:0] C_REG_STATUS   = 3'd4;

    // CTRL / STATUS bit positions
    localparam int C_CTRL_EN          = 0;
    localparam int C_CTRL_IRQ_EN      = 1;
    localparam int C_CTRL_AUTO_RELOAD = 2;
    localparam int C_STATUS_MATCH     = 0;

    localparam logic [31:0] C_COMPARE_RST = 32'hFFFF_FFFF;

    // CTRL register image; field order matches the bit positions above
    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

    // Replace the byte lanes of old_val selected by sel with those of new_val
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : wb_timer_pkg
`default_nettype wire

// File: rtl/wb_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_prescaler
// Description : Clock prescaler for wb_timer. Counts 0..i_prescale while
//               enabled and emits a one-clock tick on the terminal count, so
//               one tick occurs every i_prescale+1 clocks (every clock when
//               i_prescale is 0). Disabled or cleared, the count sits at 0.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset
//               i_en       - count enable
//               i_prescale - terminal count
//               i_clear    - restart the count from 0 (prescale rewrite)
//               o_tick     - timer tick, combinational from count state
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [PRE_W-1:0] i_prescale,
    input  logic             i_clear,
    output logic             o_tick
);

    localparam logic [PRE_W-1:0] C_PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0] r_pre;
    logic             w_terminal;

    assign w_terminal = (r_pre == i_prescale);
    assign o_tick     = i_en & w_terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (i_clear || !i_en || w_terminal) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + C_PRE_ONE;
        end
    end

endmodule : wb_timer_prescaler
`default_nettype wire

// File: rtl/wb_timer.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer
// Description : Wishbone B4 classic slave timer/compare unit. A prescaled
//               32-bit up-counter is compared against COMPARE on every tick;
//               a hit sets STATUS.MATCH (W1C) and optionally reloads COUNT
//               to 0. irq_o is the registered MATCH & CTRL.IRQ_EN level.
// Ports       : wb_clk_i / wb_rst_i      - clock, synchronous active-high reset
//               wb_adr_i                 - word address (bus adr[4:2])
//               wb_dat_i / wb_sel_i      - write data and byte enables
//               wb_we_i/wb_cyc_i/wb_stb_i- Wishbone cycle control
//               wb_cti_i / wb_bte_i      - ignored, classic cycles only
//               wb_dat_o / wb_ack_o      - read data, one-cycle acknowledge
//               wb_err_o / wb_rty_o      - tied low
//               irq_o                    - level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int          PRE_W   = 16,
    parameter logic [31:0] CNT_RST = 32'd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        irq_o
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_irq;
    ctrl_t             r_ctrl;
    logic [PRE_W-1:0]  r_prescale;
    logic [31:0]       r_count;
    logic [31:0]       r_compare;
    logic              r_match;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        w_req;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_pre;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_match_clr;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_rd_data;
    logic [31:0] w_ctrl_merged;
    logic [31:0] w_pre_merged;
    logic [31:0] w_pre_ext;
    logic [31:0] w_count_next;
    logic        w_unused_ok;

    // A new request is accepted only while ack is low, so back-to-back
    // strobes see ack on alternate cycles.
    assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;

    // Writes commit at the end of the ack cycle.
    assign w_wr         = wb_cyc_i & wb_stb_i & wb_we_i & r_ack;
    assign w_wr_ctrl    = w_wr & (wb_adr_i == C_REG_CTRL);
    assign w_wr_pre     = w_wr & (wb_adr_i == C_REG_PRESCALE);
    assign w_wr_count   = w_wr & (wb_adr_i == C_REG_COUNT);
    assign w_wr_compare = w_wr & (wb_adr_i == C_REG_COMPARE);
    assign w_wr_status  = w_wr & (wb_adr_i == C_REG_STATUS);
    assign w_match_clr  = w_wr_status & wb_sel_i[0] & wb_dat_i[C_STATUS_MATCH];

    assign w_pre_ext     = 32'(r_prescale);
    assign w_ctrl_merged = byte_merge({29'd0, r_ctrl}, wb_dat_i, wb_sel_i);
    assign w_pre_merged  = byte_merge(w_pre_ext, wb_dat_i, wb_sel_i);

    assign w_unused_ok = ^{wb_cti_i, wb_bte_i};

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    wb_timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .i_en       (r_ctrl.en),
        .i_prescale (r_prescale),
        .i_clear    (w_wr_pre),
        .o_tick     (w_tick)
    );

    // Comparison always uses the registered COMPARE, so a COMPARE write
    // landing in a tick cycle only affects later ticks.
    assign w_hit = w_tick & (r_count == r_compare);

    // COUNT next value: a software write takes precedence over the tick.
    always_comb begin
        w_count_next = r_count;
        if (w_tick) begin
            if (w_hit && r_ctrl.auto_reload) begin
                w_count_next = 32'd0;
            end else begin
                w_count_next = r_count + 32'd1;
            end
        end
        if (w_wr_count) begin
            w_count_next = byte_merge(r_count, wb_dat_i, wb_sel_i);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 32'd0;
        case (wb_adr_i)
            C_REG_CTRL:     w_rd_data = {29'd0, r_ctrl};
            C_REG_PRESCALE: w_rd_data = w_pre_ext;
            C_REG_COUNT:    w_rd_data = r_count;
            C_REG_COMPARE:  w_rd_data = r_compare;
            C_REG_STATUS:   w_rd_data = {31'd0, r_match};
            default:        w_rd_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus handshake and read data
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rd_data : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_count    <= CNT_RST;
            r_compare  <= C_COMPARE_RST;
            r_match    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= ctrl_t'(w_ctrl_merged[2:0]);
            end
            if (w_wr_pre) begin
                r_prescale <= w_pre_merged[PRE_W-1:0];
            end
            if (w_wr_compare) begin
                r_compare <= byte_merge(r_compare, wb_dat_i, wb_sel_i);
            end
            r_count <= w_count_next;

            // A set in the same cycle as a W1C clear wins.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_match_clr) begin
                r_match <= 1'b0;
            end

            r_irq <= r_match & r_ctrl.irq_en;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign irq_o    = r_irq;

endmodule : wb_timer
`default_nettype wire
